// File: rtl/jelly_fifo_srl_ctrl_pkg.sv
// Shared constants and helpers for the shift-register-LUT FIFO family.
package jelly_fifo_srl_ctrl_pkg;

    // Occupancy counter width: must represent 0..(1 << ptr_width) inclusive.
    function automatic int unsigned count_width(input int unsigned ptr_width);
        return ptr_width + 1;
    endfunction

endpackage

// File: rtl/jelly_data_shift_register_lut.sv
// Addressable shift-register LUT: shifts in on cke_i, reads the entry at sel_i.
// Index 0 always holds the newest word. Contents have no reset.
module jelly_data_shift_register_lut #(
    parameter int unsigned SEL_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter string       DEVICE     = "RTL"
) (
    input  logic                  clk,
    input  logic                  cke_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    localparam int unsigned Num = 1 << SEL_WIDTH;

    if (DEVICE == "RTL") begin : g_rtl
        logic [DATA_WIDTH-1:0] mem_q [Num];

        // Shift the whole chain by one on every enabled cycle.
        always_ff @(posedge clk) begin
            if (cke_i) begin
                mem_q[0] <= in_data_i;
                for (int i = 1; i < Num; i++) begin
                    mem_q[i] <= mem_q[i-1];
                end
            end
        end

        assign out_data_o = mem_q[sel_i];
    end else begin : g_srl
        // Vendor targets: hint the tools to map onto SRLC32E-style primitives.
        (* srl_style = "srl" *) logic [DATA_WIDTH-1:0] mem_q [Num];

        // Same chain as the generic path; attribute steers primitive mapping.
        always_ff @(posedge clk) begin
            if (cke_i) begin
                mem_q[0] <= in_data_i;
                for (int i = 1; i < Num; i++) begin
                    mem_q[i] <= mem_q[i-1];
                end
            end
        end

        assign out_data_o = mem_q[sel_i];
    end

endmodule

// File: rtl/jelly_fifo_srl_ctrl.sv
// Shift-register-LUT FIFO controller with ready/valid on both sides.
// Optional registered output stage enabled by defining JELLY_FIFO_SRL_CTRL_OUTREG_EN.
module jelly_fifo_srl_ctrl
    import jelly_fifo_srl_ctrl_pkg::*;
#(
    parameter int unsigned PTR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter string       DEVICE     = "RTL"
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,

    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,

    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,

    output logic [PTR_WIDTH:0]    data_count
);

    localparam int unsigned NUM         = 1 << PTR_WIDTH;
    localparam int unsigned COUNT_WIDTH = count_width(PTR_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] NumCount = COUNT_WIDTH'(NUM);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   srl_pop;
    logic [PTR_WIDTH-1:0]   sel;
    logic [DATA_WIDTH-1:0]  lut_data;

    assign empty   = (count_q == '0);
    assign full    = (count_q == NumCount);
    // No pass-through when full: a same-cycle pop does not open the input.
    assign s_ready = ~full & ~reset;
    assign push    = cke & s_valid & s_ready;
    // Oldest entry sits at count-1 because every push shifts toward higher indices.
    assign sel     = empty ? '0 : PTR_WIDTH'(count_q - COUNT_WIDTH'(1));

    jelly_data_shift_register_lut #(
        .SEL_WIDTH  (PTR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEVICE     (DEVICE)
    ) u_srl (
        .clk        (clk),
        .cke_i      (push),
        .sel_i      (sel),
        .in_data_i  (s_data),
        .out_data_o (lut_data)
    );

`ifdef JELLY_FIFO_SRL_CTRL_OUTREG_EN
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    // Refill the output stage whenever it is empty or being drained.
    assign srl_pop = cke & ~empty & (~out_valid_q | m_ready);

    // Output register: load on SRL pop, clear once consumed with nothing behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (cke) begin
            if (srl_pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= lut_data;
            end else if (m_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid    = out_valid_q;
    assign m_data     = out_data_q;
    assign data_count = count_q + COUNT_WIDTH'(out_valid_q);
`else
    assign srl_pop    = cke & ~empty & m_ready;
    assign m_valid    = ~empty;
    assign m_data     = lut_data;
    assign data_count = count_q;
`endif

    // Occupancy next state; push and pop together leave count and sel unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, srl_pop})
            2'b10:   count_d = count_q + COUNT_WIDTH'(1);
            2'b01:   count_d = count_q - COUNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy register; cke gating is already folded into push/srl_pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_jelly_fifo_srl_ctrl.sv
// Self-checking bench for jelly_fifo_srl_ctrl (PTR_WIDTH=2, NUM=4, DATA_WIDTH=8).
// Directed vector table followed by randomized traffic against a queue model.
module tb_jelly_fifo_srl_ctrl;

    localparam int unsigned PW  = 2;
    localparam int unsigned NUM = 1 << PW;
    localparam int unsigned DW  = 8;

    logic          reset;
    logic          clk;
    logic          cke;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [PW:0]   data_count;

    int checks;
    int errors;

    jelly_fifo_srl_ctrl #(
        .PTR_WIDTH  (PW),
        .DATA_WIDTH (DW),
        .DEVICE     ("RTL")
    ) dut (
        .reset      (reset),
        .clk        (clk),
        .cke        (cke),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          cke;
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          ev;
        logic [DW-1:0] ed;
        logic          esr;
        logic [PW:0]   edc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic ck, input logic sv,
                                input logic [DW-1:0] sd, input logic mr, input logic ev,
                                input logic [DW-1:0] ed, input logic esr, input int edc);
        vec_t v;
        v.rst = rst; v.cke = ck; v.sv = sv; v.sd = sd; v.mr = mr;
        v.ev = ev; v.ed = ed; v.esr = esr; v.edc = (PW+1)'(edc);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [DW-1:0] ed,
                                 input logic esr, input logic [PW:0] edc);
        check({tag, " m_valid"}, 32'(m_valid), 32'(ev));
        check({tag, " s_ready"}, 32'(s_ready), 32'(esr));
        check({tag, " data_count"}, 32'(data_count), 32'(edc));
        if (ev) check({tag, " m_data"}, 32'(m_data), 32'(ed));
    endtask

    task automatic drive(input logic rst, input logic ck, input logic sv,
                         input logic [DW-1:0] sd, input logic mr);
        @(negedge clk);
        reset = rst; cke = ck; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
    endtask

    // Reference model: SRL contents as a queue plus an optional output slot.
    logic [DW-1:0] q[$];
    logic          ov;
    logic [DW-1:0] od;

    function automatic void model_step(input logic rst, input logic ck, input logic sv,
                                       input logic [DW-1:0] sd, input logic mr);
        logic do_push;
        if (rst) begin
            q.delete();
            ov = 1'b0;
            od = '0;
        end else if (ck) begin
            do_push = sv && (q.size() < NUM);
`ifdef JELLY_FIFO_SRL_CTRL_OUTREG_EN
            if (q.size() > 0 && (!ov || mr)) begin
                od = q.pop_front();
                ov = 1'b1;
            end else if (mr) begin
                ov = 1'b0;
            end
`else
            if (mr && q.size() > 0) void'(q.pop_front());
`endif
            if (do_push) q.push_back(sd);
        end
    endfunction

    initial begin
        logic          r_rst, r_cke, r_sv, r_mr;
        logic [DW-1:0] r_sd;
        logic          e_v, e_sr;
        logic [DW-1:0] e_d;
        logic [PW:0]   e_dc;
        int            bias_sv, bias_mr;

        checks = 0; errors = 0;
        reset = 1'b1; cke = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        ov = 1'b0; od = '0;

        // Vector table: rst cke sv sd mr | m_valid m_data s_ready data_count
        add(1,1,0,8'h00,0, 0,8'h00,0,0);
`ifndef JELLY_FIFO_SRL_CTRL_OUTREG_EN
        // Fill with m_ready=0, fifth word refused.
        add(0,1,1,8'h11,0, 0,8'h00,1,0);
        add(0,1,1,8'h22,0, 1,8'h11,1,1);
        add(0,1,1,8'h33,0, 1,8'h11,1,2);
        add(0,1,1,8'h44,0, 1,8'h11,1,3);
        add(0,1,1,8'h55,0, 1,8'h11,0,4);
        add(0,1,0,8'h00,0, 1,8'h11,0,4);
        // Drain from full.
        add(0,1,0,8'h00,1, 1,8'h11,0,4);
        add(0,1,0,8'h00,1, 1,8'h22,1,3);
        add(0,1,0,8'h00,1, 1,8'h33,1,2);
        add(0,1,0,8'h00,1, 1,8'h44,1,1);
        add(0,1,0,8'h00,1, 0,8'h00,1,0);
        // Simultaneous push/pop at count=2.
        add(0,1,1,8'hA1,0, 0,8'h00,1,0);
        add(0,1,1,8'hA2,0, 1,8'hA1,1,1);
        add(0,1,1,8'hA3,1, 1,8'hA1,1,2);
        add(0,1,1,8'hA4,1, 1,8'hA2,1,2);
        add(0,1,1,8'hA5,1, 1,8'hA3,1,2);
        add(0,1,1,8'hA6,1, 1,8'hA4,1,2);
        add(0,1,0,8'h00,0, 1,8'hA5,1,2);
        // cke=0 for three cycles with s_valid=m_ready=1.
        add(0,0,1,8'hB1,1, 1,8'hA5,1,2);
        add(0,0,1,8'hB1,1, 1,8'hA5,1,2);
        add(0,0,1,8'hB1,1, 1,8'hA5,1,2);
        add(0,1,1,8'hB1,1, 1,8'hA5,1,2);
        add(0,1,0,8'h00,1, 1,8'hA6,1,2);
        add(0,1,0,8'h00,1, 1,8'hB1,1,1);
        add(0,1,0,8'h00,0, 0,8'h00,1,0);
        // Reset at count=3, then a fresh word must not see stale data.
        add(0,1,1,8'hC1,0, 0,8'h00,1,0);
        add(0,1,1,8'hC2,0, 1,8'hC1,1,1);
        add(0,1,1,8'hC3,0, 1,8'hC1,1,2);
        add(1,1,0,8'h00,0, 1,8'hC1,0,3);
        add(0,1,1,8'h77,0, 0,8'h00,1,0);
        add(0,1,0,8'h00,1, 1,8'h77,1,1);
        add(0,1,0,8'h00,0, 0,8'h00,1,0);
`else
        // Two-cycle latency, capacity NUM+1, in-order drain.
        add(0,1,1,8'h01,0, 0,8'h00,1,0);
        add(0,1,1,8'h02,0, 0,8'h00,1,1);
        add(0,1,1,8'h03,0, 1,8'h01,1,2);
        add(0,1,1,8'h04,0, 1,8'h01,1,3);
        add(0,1,1,8'h05,0, 1,8'h01,1,4);
        add(0,1,1,8'h06,0, 1,8'h01,0,5);
        add(0,1,0,8'h00,1, 1,8'h01,0,5);
        add(0,1,0,8'h00,1, 1,8'h02,1,4);
        add(0,1,0,8'h00,1, 1,8'h03,1,3);
        add(0,1,0,8'h00,1, 1,8'h04,1,2);
        add(0,1,0,8'h00,1, 1,8'h05,1,1);
        add(0,1,0,8'h00,0, 0,8'h00,1,0);
`endif

        // Bring the DUT to a known state before the table.
        drive(1, 1, 0, 8'h00, 0);
        drive(1, 1, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].cke, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].esr,
                          vecs[i].edc);
        end

        // Randomized traffic; iteration 0 is a reset that aligns the model.
        bias_sv = 80; bias_mr = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                bias_sv = 110 - bias_sv;
                bias_mr = 110 - bias_mr;
            end
            r_rst = (i == 0) || ($urandom_range(0, 99) == 0);
            r_cke = ($urandom_range(0, 4) != 0);
            r_sv  = ($urandom_range(0, 99) < bias_sv);
            r_mr  = ($urandom_range(0, 99) < bias_mr);
            r_sd  = DW'($urandom);
            drive(r_rst, r_cke, r_sv, r_sd, r_mr);
            if (i > 0) begin
                e_sr = !r_rst && (q.size() < NUM);
`ifdef JELLY_FIFO_SRL_CTRL_OUTREG_EN
                e_v  = ov;
                e_d  = od;
                e_dc = (PW+1)'(q.size()) + (PW+1)'(ov);
`else
                e_v  = (q.size() > 0);
                e_d  = e_v ? q[0] : '0;
                e_dc = (PW+1)'(q.size());
`endif
                check_outputs($sformatf("rnd%0d", i), e_v, e_d, e_sr, e_dc);
            end
            model_step(r_rst, r_cke, r_sv, r_sd, r_mr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jelly_fifo_srl_ctrl.md
Name: jelly_fifo_srl_ctrl

Overview:
- Synchronous FIFO with a ready/valid stream on both sides.
- Storage is an addressable shift-register LUT; this block sequences it.
  - The LUT shifts on every accepted push.
  - An occupancy counter drives the LUT read select so the oldest entry is always presented.
- Used for shallow, LUT-resident buffering (≤32 entries/bit on Xilinx) between pipeline stages; replaces a BRAM FIFO where depth is small.

Parameters:
- PTR_WIDTH, 5: log2 of SRL depth; NUM = 1<<PTR_WIDTH entries.
- DATA_WIDTH, 8: payload width.
- DEVICE, "RTL": passed unchanged to the shift-register LUT ("7SERIES", "ULTRASCALE", etc. map to SRLC32E).

Ports:
- reset  in  1  synchronous reset, active-high.
- clk  in  1  clock; all logic on rising edge.
- cke  in  1  clock enable; when 0, all state holds and no transfer occurs.
- s_data  in  DATA_WIDTH  input payload.
- s_valid  in  1  input valid.
- s_ready  out  1  input ready.
- m_data  out  DATA_WIDTH  output payload.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.
- data_count  out  PTR_WIDTH+1  entries held (SRL plus output register if present).

Behaviour:
- Transfer rules:
  - push = cke & s_valid & s_ready.
  - pop = cke & m_valid & m_ready.
  - s_valid/s_data are sampled only when push is true.
- Counter: count register, PTR_WIDTH+1 bits, range 0..NUM.
- Shift-register LUT control:
  - LUT cke = push; LUT in_data = s_data.
  - LUT sel = count-1, truncated to PTR_WIDTH bits; sel = 0 when count = 0 (output is don't-care).
- Count update:
  - push only → count+1.
  - SRL pop only → count-1.
  - both in the same cycle → count unchanged, sel unchanged. The new oldest entry moves into the same index.
- Combinational flags:
  - s_ready = (count != NUM) & ~reset. No pass-through when full: push is refused even if a pop occurs in that cycle.
  - empty = (count == 0).
- Default, no output register:
  - m_valid = ~empty; m_data = LUT out_data (combinational from sel).
  - Latency: word pushed in cycle t is visible at m_valid in cycle t+1.
  - Capacity is NUM.
- Reset (synchronous, any time, including mid-burst):
  - count = 0, m_valid = 0, s_ready = 0 while reset is high, data_count = 0.
  - SRL contents are not cleared (don't-care).
  - First cycle after reset deasserts: s_ready = 1.
- cke = 0: count, output register and SRL hold. m_valid/s_ready keep their values and no handshake completes.
- Ordering: strict FIFO; no drop, no duplication under any push/pop combination.
- data_count = count (plus out_valid when the option is enabled); registered-state derived, no extra latency.

Optional Feature:
Macro: JELLY_FIFO_SRL_CTRL_OUTREG_EN
- Defined: adds a registered output stage (out_valid, out_data) for timing closure.
  - SRL pop = cke & (count != 0) & (~out_valid | m_ready); out_data <= LUT out_data, out_valid <= 1 on SRL pop.
  - out_valid <= 0 when m_ready & ~SRL pop.
  - m_valid = out_valid; m_data = out_data.
  - out_valid resets to 0 and out_data resets to 0.
  - Latency 2 cycles (push at t → m_valid at t+2); capacity NUM+1; data_count = count + out_valid.
- Undefined: default combinational output path above; latency 1; capacity NUM.

Decomposition:
- No package types needed. Local constants: NUM and COUNT_WIDTH = PTR_WIDTH+1.
  - If a shared FIFO package exists, COUNT_WIDTH derivation belongs there for reuse by sibling FIFOs.
- One sub-module: jelly_data_shift_register_lut (SEL_WIDTH=PTR_WIDTH, DATA_WIDTH, DEVICE) as the storage datapath.
- Controller (counter, flags, output register) stays in this module.

Test Plan (PTR_WIDTH=2, NUM=4, DATA_WIDTH=8):
- Fill with m_ready=0: push 0x11,0x22,0x33,0x44 → data_count steps 1..4, s_ready=0 after 4th. A fifth s_valid with 0x55 is not accepted.
- Drain from full with m_ready=1 → m_data 0x11,0x22,0x33,0x44 on consecutive cycles, then m_valid=0, data_count=0, s_ready=1.
- Simultaneous push/pop at count=2 (holding 0xA1,0xA2, pushing 0xA3..0xA6 while popping each cycle) → data_count stays 2. Output sequence is 0xA1,0xA2,0xA3,0xA4, with 0xA5,0xA6 remaining.
- cke=0 for 3 cycles mid-stream with s_valid=m_ready=1 → no count change, no output advance; stream resumes in order after cke=1.
- Reset asserted at count=3 → next cycle m_valid=0, data_count=0. Push 0x77 after release → first output is 0x77, not stale data.
- With JELLY_FIFO_SRL_CTRL_OUTREG_EN: push 0x01 at cycle t → m_valid at t+2. Fill with m_ready=0 → 5 entries accepted, data_count=5. Drain order is 0x01..0x05.
